// File: rtl/hier_check_pkg.sv
// Shared types and default constants for the counter/offset hierarchy and its checker.
package hier_check_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Offsets the generator side adds to its counter; the checker removes them again.
    localparam int DEF_OFFSET_A = 2;
    localparam int DEF_OFFSET_B = 5;

endpackage

// File: rtl/stream_offset_decoder.sv
// Registered removal of a fixed offset from one incoming data stream.
module stream_offset_decoder #(
    parameter int WIDTH  = 32,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] dec_out
);

    // Subtract the offset modulo 2^WIDTH so a wrapped generator counter decodes cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_out <= '0;
        end else begin
            dec_out <= data_in - WIDTH'(OFFSET);
        end
    end

endmodule

// File: rtl/hierarchy_stream_checker.sv
// Self-checking sink for the two offset streams of the counter hierarchy.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | checking disabled (en_r=0); counters cleared
//   ACQUIRE | searching for LOCK_COUNT consecutive in-sequence samples
//   LOCKED  | tracking the sequence; bad samples counted as errors
module hierarchy_stream_checker
    import hier_check_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OFFSET_A   = DEF_OFFSET_A,
    parameter int OFFSET_B   = DEF_OFFSET_B,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 check_en,
    input  logic                 clear_errors,
    input  logic [WIDTH-1:0]     data_a_in,
    input  logic [WIDTH-1:0]     data_b_in,
    output logic [WIDTH-1:0]     decoded_out,
    output logic                 decoded_valid,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [ERR_WIDTH-1:0] error_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int NW = $clog2(LOSS_COUNT + 1);

    logic [WIDTH-1:0]     a_dec_r;
    logic [WIDTH-1:0]     b_dec_r;
    logic                 en_r;
    state_t               state;
    logic [WIDTH-1:0]     expected;
    logic [MW-1:0]        match_cnt;
    logic [NW-1:0]        miss_cnt;

    logic                 pair_eq;
    logic                 seq_eq;
    logic                 good;
    logic [MW-1:0]        match_next;
    logic [NW-1:0]        miss_next;
    logic [ERR_WIDTH-1:0] err_sat_next;

    stream_offset_decoder #(
        .WIDTH  (WIDTH),
        .OFFSET (OFFSET_A)
    ) u_dec_a (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_a_in),
        .dec_out (a_dec_r)
    );

    stream_offset_decoder #(
        .WIDTH  (WIDTH),
        .OFFSET (OFFSET_B)
    ) u_dec_b (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_b_in),
        .dec_out (b_dec_r)
    );

    // Qualifier travels with the decoded sample so both belong to the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r <= 1'b0;
        end else begin
            en_r <= check_en;
        end
    end

    assign decoded_out   = a_dec_r;
    assign decoded_valid = en_r & pair_eq;

    // Per-sample compare results and the candidate counter values for this edge.
    always_comb begin
        pair_eq      = (a_dec_r == b_dec_r);
        seq_eq       = (a_dec_r == expected);
        good         = en_r & pair_eq & seq_eq;
        match_next   = '0;
        if (pair_eq) begin
            match_next = seq_eq ? (match_cnt + MW'(1)) : MW'(1);
        end
        miss_next    = miss_cnt + NW'(1);
        err_sat_next = (error_count == '1) ? error_count : (error_count + ERR_WIDTH'(1));
    end

    // Lock FSM, sequence tracking and error accounting, all evaluated on the stage-1 sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            expected    <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= '0;
        end else begin
            error_pulse <= 1'b0;
            if (clear_errors) begin
                error_count <= '0;
            end
            if (!en_r) begin
                state     <= IDLE;
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b0;
            end else begin
                unique case (state)
                    // IDLE falls straight into the acquire rules for this same sample.
                    IDLE, ACQUIRE: begin
                        match_cnt <= match_next;
                        miss_cnt  <= '0;
                        if (pair_eq) begin
                            expected <= a_dec_r + WIDTH'(1);
                        end
                        if (match_next == MW'(LOCK_COUNT)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= ACQUIRE;
                            locked <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        // The sequence advances regardless of sample quality.
                        expected <= expected + WIDTH'(1);
                        if (good) begin
                            miss_cnt <= '0;
                        end else begin
                            error_pulse <= 1'b1;
                            error_count <= clear_errors ? ERR_WIDTH'(1) : err_sat_next;
                            if (miss_next == NW'(LOSS_COUNT)) begin
                                state     <= ACQUIRE;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                                expected  <= a_dec_r + WIDTH'(1);
                            end else begin
                                miss_cnt <= miss_next;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hierarchy_stream_checker.sv
// Directed bench for hierarchy_stream_checker; a second instance with a 4-bit
// error counter shares all inputs to exercise saturation.
module tb_hierarchy_stream_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        check_en;
    logic        clear_errors;
    logic [31:0] data_a_in;
    logic [31:0] data_b_in;

    logic [31:0] decoded_out;
    logic        decoded_valid;
    logic        locked;
    logic        error_pulse;
    logic [15:0] error_count;

    logic [31:0] decoded_out4;
    logic        decoded_valid4;
    logic        locked4;
    logic        error_pulse4;
    logic [3:0]  error_count4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hierarchy_stream_checker dut (
        .clk           (clk),
        .reset         (reset),
        .check_en      (check_en),
        .clear_errors  (clear_errors),
        .data_a_in     (data_a_in),
        .data_b_in     (data_b_in),
        .decoded_out   (decoded_out),
        .decoded_valid (decoded_valid),
        .locked        (locked),
        .error_pulse   (error_pulse),
        .error_count   (error_count)
    );

    hierarchy_stream_checker #(.ERR_WIDTH(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .check_en      (check_en),
        .clear_errors  (clear_errors),
        .data_a_in     (data_a_in),
        .data_b_in     (data_b_in),
        .decoded_out   (decoded_out4),
        .decoded_valid (decoded_valid4),
        .locked        (locked4),
        .error_pulse   (error_pulse4),
        .error_count   (error_count4)
    );

    // Drive one sample for counter value n (b optionally corrupted), step one edge.
    task automatic push(input logic [31:0] n, input logic [31:0] berr);
        data_a_in = n + 32'd2;
        data_b_in = n + 32'd5 + berr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        check_en     = 1'b0;
        clear_errors = 1'b0;
        data_a_in    = '0;
        data_b_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic lock_at(input logic [31:0] n0);
        check_en = 1'b1;
        for (int i = 0; i < 4; i++) push(n0 + 32'(i), 32'd0);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        check_en     = 1'b1;
        clear_errors = 1'b0;
        data_a_in    = 32'd7;
        data_b_in    = 32'd10;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (decoded_out !== 32'd0) begin bad++; $display("FAIL reset_decoded: got %0h want 0", decoded_out); end
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
        total++;
        if (error_count !== 16'd0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", error_count); end
        total++;
        if (error_pulse !== 1'b0 || decoded_valid !== 1'b0) begin
            bad++; $display("FAIL reset_pulse_valid: got %0b/%0b want 0/0", error_pulse, decoded_valid);
        end
        reset = 1'b1;
        check_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_aligned();
        do_reset();
        check_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(32'(i), 32'd0);
            total++;
            if (decoded_out !== 32'(i)) begin bad++; $display("FAIL aligned_decoded[%0d]: got %0h want %0h", i, decoded_out, i); end
            total++;
            if (decoded_valid !== 1'b1) begin bad++; $display("FAIL aligned_valid[%0d]: got %0b want 1", i, decoded_valid); end
            total++;
            if (locked !== (i >= 4)) begin bad++; $display("FAIL aligned_locked[%0d]: got %0b want %0b", i, locked, (i >= 4)); end
            total++;
            if (error_count !== 16'd0) begin bad++; $display("FAIL aligned_errcnt[%0d]: got %0d want 0", i, error_count); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] n;
        do_reset();
        lock_at(32'hFFFF_FFF9);
        n = 32'hFFFF_FFFD;
        repeat (5) begin
            push(n, 32'd0);
            total++;
            if (decoded_out !== n) begin bad++; $display("FAIL wrap_decoded: got %0h want %0h", decoded_out, n); end
            total++;
            if (locked !== 1'b1) begin bad++; $display("FAIL wrap_locked at %0h: got %0b want 1", n, locked); end
            total++;
            if (error_pulse !== 1'b0) begin bad++; $display("FAIL wrap_pulse at %0h: got %0b want 0", n, error_pulse); end
            n = n + 32'd1;
        end
        push(n, 32'd0);
        total++;
        if (locked !== 1'b1 || error_count !== 16'd0) begin
            bad++; $display("FAIL wrap_final: got locked=%0b errs=%0d want 1/0", locked, error_count);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        lock_at(32'd16);
        for (int n = 20; n <= 25; n++) begin
            push(32'(n), (n == 20) ? 32'd1 : 32'd0);
            total++;
            if (error_pulse !== (n == 21)) begin bad++; $display("FAIL single_pulse[%0d]: got %0b want %0b", n, error_pulse, (n == 21)); end
            total++;
            if (error_count !== ((n >= 21) ? 16'd1 : 16'd0)) begin
                bad++; $display("FAIL single_errcnt[%0d]: got %0d want %0d", n, error_count, (n >= 21) ? 1 : 0);
            end
            total++;
            if (locked !== 1'b1) begin bad++; $display("FAIL single_locked[%0d]: got %0b want 1", n, locked); end
        end
    endtask

    task automatic test_loss_reacquire();
        logic [15:0] exp_cnt;
        do_reset();
        lock_at(32'd30);
        for (int n = 34; n <= 36; n++) push(32'(n), 32'd0);
        for (int n = 37; n <= 44; n++) begin
            push(32'(n), (n >= 37 && n <= 39) ? 32'd1 : 32'd0);
            exp_cnt = (n <= 37) ? 16'd0 : (n == 38) ? 16'd1 : (n == 39) ? 16'd2 : 16'd3;
            total++;
            if (error_count !== exp_cnt) begin bad++; $display("FAIL loss_errcnt[%0d]: got %0d want %0d", n, error_count, exp_cnt); end
            total++;
            if (locked !== (n <= 39 || n >= 44)) begin
                bad++; $display("FAIL loss_locked[%0d]: got %0b want %0b", n, locked, (n <= 39 || n >= 44));
            end
            total++;
            if (error_pulse !== (n >= 38 && n <= 40)) begin
                bad++; $display("FAIL loss_pulse[%0d]: got %0b want %0b", n, error_pulse, (n >= 38 && n <= 40));
            end
        end
    endtask

    task automatic test_saturation_clear();
        logic [31:0] n;
        do_reset();
        lock_at(32'd50);
        n = 32'd54;
        for (int i = 0; i < 20; i++) begin
            push(n, 32'd1);
            push(n + 32'd1, 32'd0);
            n = n + 32'd2;
            total++;
            if (error_count4 !== ((i + 1 > 15) ? 4'd15 : 4'(i + 1))) begin
                bad++; $display("FAIL sat_errcnt4[%0d]: got %0d want %0d", i, error_count4, (i + 1 > 15) ? 15 : i + 1);
            end
            total++;
            if (error_count !== 16'(i + 1)) begin bad++; $display("FAIL sat_errcnt16[%0d]: got %0d want %0d", i, error_count, i + 1); end
            total++;
            if (locked4 !== 1'b1) begin bad++; $display("FAIL sat_locked[%0d]: got %0b want 1", i, locked4); end
        end
        push(n, 32'd1);
        clear_errors = 1'b1;
        push(n + 32'd1, 32'd0);
        clear_errors = 1'b0;
        total++;
        if (error_count4 !== 4'd1 || error_count !== 16'd1) begin
            bad++; $display("FAIL clear_with_error: got %0d/%0d want 1/1", error_count4, error_count);
        end
        total++;
        if (error_pulse4 !== 1'b1) begin bad++; $display("FAIL clear_pulse: got %0b want 1", error_pulse4); end
        push(n + 32'd2, 32'd0);
        total++;
        if (error_count4 !== 4'd1 || error_pulse4 !== 1'b0) begin
            bad++; $display("FAIL clear_after: got cnt=%0d pulse=%0b want 1/0", error_count4, error_pulse4);
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [31:0] n;
        do_reset();
        lock_at(32'd0);
        push(32'd4, 32'd0);
        n = 32'd5;
        repeat (5) begin
            push(n, 32'd1);
            push(n + 32'd1, 32'd0);
            n = n + 32'd2;
        end
        total++;
        if (error_count !== 16'd5 || locked !== 1'b1) begin
            bad++; $display("FAIL midreset_pre: got errs=%0d locked=%0b want 5/1", error_count, locked);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (decoded_out !== 32'd0) begin bad++; $display("FAIL midreset_decoded: got %0h want 0", decoded_out); end
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL midreset_locked: got %0b want 1'b0", locked); end
        total++;
        if (error_count !== 16'd0) begin bad++; $display("FAIL midreset_errcnt: got %0d want 0", error_count); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            push(32'(i), 32'd0);
            total++;
            if (locked !== (i >= 4) || error_count !== 16'd0) begin
                bad++; $display("FAIL relock[%0d]: got locked=%0b errs=%0d want %0b/0", i, locked, error_count, (i >= 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wrap();
        test_single_error();
        test_loss_reacquire();
        test_saturation_clear();
        test_reset_mid_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hierarchy_stream_checker.md
Name: hierarchy_stream_checker

Overview:
- Receive-side counterpart to the counter/offset-adder hierarchy.
- Consumes the two offset data streams (counter+OFFSET_A and counter+OFFSET_B), subtracts the offsets and cross-checks the two decoded values.
- Locks onto the incrementing sequence and counts corruption events.
- Sits beside the generator hierarchy as a self-checking sink for simulation and regression.

Parameters:
- WIDTH, 32, data path width.
- OFFSET_A, 2, offset added on stream A; subtracted here.
- OFFSET_B, 5, offset added on stream B; subtracted here.
- LOCK_COUNT, 4, consecutive good samples needed to reach LOCKED.
- LOSS_COUNT, 3, consecutive bad samples in LOCKED that force ACQUIRE.
- ERR_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- check_en  input  1  sample-qualify; 0 forces IDLE.
- clear_errors  input  1  synchronous clear of error_count.
- data_a_in  input  WIDTH  stream A (counter+OFFSET_A).
- data_b_in  input  WIDTH  stream B (counter+OFFSET_B).
- decoded_out  output  WIDTH  registered data_a_in-OFFSET_A.
- decoded_valid  output  1  high when the registered A and B decodes agree and en_r=1.
- locked  output  1  high in LOCKED.
- error_pulse  output  1  one-cycle pulse per error counted.
- error_count  output  ERR_WIDTH  saturating error total.

Behaviour:
- Reset (async, reset=0): every register and output is 0; state=IDLE; expected=0; match_cnt=0; miss_cnt=0.
- Stage 1, every clk edge:
  - a_dec_r <= data_a_in-OFFSET_A and b_dec_r <= data_b_in-OFFSET_B, both mod 2^WIDTH.
  - en_r <= check_en.
  - decoded_out = a_dec_r, so latency is 1 cycle.
- good = en_r & (a_dec_r==b_dec_r) & (a_dec_r==expected). All compares are WIDTH-bit; 0xFFFFFFFF followed by 0 is in sequence.
- en_r=0 in any state: next state is IDLE; match_cnt and miss_cnt clear; error_count holds; no error_pulse.
- IDLE: when en_r=1, go to ACQUIRE and evaluate that sample with the ACQUIRE rules in the same edge.
- ACQUIRE:
  - a_dec_r==b_dec_r: match_cnt <= (a_dec_r==expected) ? match_cnt+1 : 1, and expected <= a_dec_r+1.
  - a_dec_r!=b_dec_r: match_cnt <= 0.
  - The edge on which match_cnt becomes LOCK_COUNT moves to LOCKED, with miss_cnt=0.
  - No errors are counted in ACQUIRE.
- LOCKED:
  - expected <= expected+1 every en_r cycle, good or bad.
  - good: miss_cnt <= 0.
  - bad: error_pulse=1 next cycle; error_count increments, saturating at all-ones; miss_cnt increments.
  - When miss_cnt reaches LOSS_COUNT: go to ACQUIRE, match_cnt <= 0, expected <= a_dec_r+1.
- locked, error_pulse and error_count are registered and update on the edge that evaluates the stage-1 sample, i.e. 1 cycle after decoded_out shows it.
- clear_errors and an error on the same edge give error_count=1 and error_pulse=1.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package hier_check_pkg:
  - state enum {IDLE, ACQUIRE, LOCKED}.
  - Default constants DEF_OFFSET_A=2 and DEF_OFFSET_B=5, shared with the generator modules.
- One sub-module, stream_offset_decoder:
  - Parameterised WIDTH and OFFSET.
  - Registered subtract with async active-low reset.
  - Instantiated twice (A and B).
- The FSM and counters stay in the top module.

Test Plan:
- Aligned startup: reset released, check_en=1, a=n+2 and b=n+5 for n=0..9 → decoded_out 0..9 one cycle after each input; locked rises 1 cycle after decoded_out==3; error_count=0.
- Wrap-around: locked, with n stepping 0xFFFFFFFD→0xFFFFFFFE→0xFFFFFFFF→0→1 (a=0xFFFFFFFF,0,1,2,3) → decoded_out 0xFFFFFFFD..1; locked stays 1; no error_pulse.
- Single corruption: locked at n=20, drive b=26 (instead of 25) once → exactly one error_pulse, error_count=1, locked stays 1, n=21.. produce no further errors.
- Loss and reacquire: locked, 3 consecutive samples with b=n+6 → error_count=3 and locked falls after the third; then good n=40..43 → locked rises 1 cycle after decoded_out==43, error_count stays 3.
- Saturation and clear: ERR_WIDTH=4, locked, 20 alternating bad/good samples → error_count stops at 15. Then assert clear_errors on the same edge as a bad sample → error_count=1.
- Reset mid-lock: pull reset low between edges while locked with error_count=5 → decoded_out, locked and error_count read 0 immediately. After release, good n=0..3 relock with no errors.
